fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the write port of one `sync_fifo` among `N_REQ` producers. Each producer presents data with a req/gnt handshake. The arbiter grants one owner at a time for a bounded burst, then drives the FIFO's `wq`/`wr_data` and honours `full`. It sits directly in front of the FIFO's write side; the read side is untouched.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: beat width; matches the FIFO's `DATA_WIDTH`.
- `MAX_BURST`, 4: maximum beats per grant, 1..15.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N_REQ  per-requester beat valid.
- `req_data`  in  N_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  N_REQ  marks the final beat of requester i's packet; qualified by req[i].
- `gnt`  out  N_REQ  one-hot-or-zero ready; a beat transfers when req[i] && gnt[i].
- `fifo_full`  in  1  from FIFO `full`.
- `fifo_wq`  out  1  to FIFO `wq`.
- `fifo_wr_data`  out  DATA_WIDTH  to FIFO `wr_data`.
- `owner`  out  clog2(N_REQ)  index of the current grant holder.
- `busy`  out  1  high in GRANT.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner holds the port; beat counter `cnt` (clog2(MAX_BURST+1) bits) counts accepted beats.
- Round-robin pointer `last` holds the index of the previous owner. The search starts at last+1, wraps modulo N_REQ, and picks the first set req bit.
- IDLE → GRANT when |req: owner <= pick, cnt <= 0. IDLE costs one cycle; no beat transfers in IDLE.
- `gnt[i]` = (state==GRANT) && (owner==i) && !fifo_full && !rst. This is combinational.
- `fifo_wq` = |(req & gnt). `fifo_wr_data` = req_data slice of owner. wr_data is don't-care when fifo_wq=0; drive the owner slice anyway.
- A beat increments cnt. The grant is released at the end of the cycle when any of these holds:
  - an accepted beat has req_last=1;
  - an accepted beat brings cnt to MAX_BURST;
  - req[owner]=0, whether or not the FIFO is full.
- On release: last <= owner. If any req is set in that cycle, re-pick from owner+1 and stay in GRANT with cnt <= 0, with no bubble. The old owner is eligible only if no other req is set. Otherwise go to IDLE.
- `fifo_full`=1 stalls the current owner. cnt holds and the grant is not released by fullness alone.
- Other requesters' req/data are ignored while not owner. They must hold req until granted.

## Timing
- Reset values: state=IDLE, owner=0, last=N_REQ-1 (requester 0 wins first), cnt=0, gnt=0, fifo_wq=0, busy=0.
- Assertion of rst mid-burst forces gnt=0 and fifo_wq=0 in that same cycle. No beat is written and everything returns to reset values next cycle.
- Latency:
  - From req rising in IDLE to the first gnt: 1 cycle.
  - Back-to-back handover between owners: 0 idle cycles.
- Combinational path req/fifo_full → gnt/fifo_wq is intended. The FIFO registers the write.
- Throughput: 1 beat/cycle while the FIFO is not full.

## Structure
- Package `fifo_arb_pkg`:
  - state enum {IDLE, GRANT};
  - function clog2;
  - the localparams IDX_W and CNT_W derived from N_REQ/MAX_BURST.
- Sub-module `rr_pick`: purely combinational. Inputs req and last; outputs idx and any. It is instantiated twice: once for the IDLE pick, once for the release re-pick (mask excluding owner, fallback to owner).
- Top level holds the FSM, counters and output mux; it does not instantiate the FIFO.

## Test plan
- Reset, then req=4'b0101 held, MAX_BURST=4, no last → owner 0 gets 4 beats, then owner 2 gets 4 beats with no gap, then owner 0 again. fifo_wq high on every GRANT cycle after the first IDLE cycle.
- req[1] only, req_last on the 2nd beat, req[3] pending → exactly 2 beats from 1, then owner=3 the next cycle.
- fifo_full=1 for 3 cycles mid-burst of owner 0 (cnt=2) → gnt=0 and fifo_wq=0 for 3 cycles, cnt stays 2, burst resumes and ends after 2 more beats.
- Owner 2 drops req while fifo_full=1, no other req → release to IDLE, last=2, busy=0 next cycle.
- rst asserted during an active beat from owner 1 → fifo_wq=0 that cycle; next cycle state=IDLE, owner=0. Subsequent req=4'b1111 grants owner 0 first.
- Only req[0] asserted continuously, MAX_BURST=2 → bursts of 2 beats with no bubble between (self-regrant), FIFO receives data in order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2, never less than one bit so indices always have a width.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int N_REQ_DEF     = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int IDX_W         = clog2(N_REQ_DEF);
  localparam int CNT_W         = clog2(MAX_BURST_DEF + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward
// from last+1, wrapping back to bit 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] above;

  always_comb begin
    above = '0;
    for (int j = 0; j < N; j++) begin
      above[j] = req[j] && (j > int'(last));
    end
    any = |req;
    idx = '0;
    // Lowest set bit overall is the wrap-around fallback; a set bit above
    // last takes precedence.
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) idx = IW'(j);
    end
    if (|above) begin
      for (int j = N - 1; j >= 0; j--) begin
        if (above[j]) idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// with bounded bursts and zero-bubble handover between owners.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        fifo_full,
  output logic                        fifo_wq,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  output logic [clog2(N_REQ)-1:0]     owner,
  output logic                        busy
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(MAX_BURST + 1);

  arb_state_e      state_reg;
  logic [IW-1:0]   owner_reg;
  logic [IW-1:0]   last_reg;
  logic [CW-1:0]   cnt_reg;

  logic [N_REQ-1:0]      owner_onehot;
  logic [DATA_WIDTH-1:0] slice_data [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign owner_onehot[gi] = (owner_reg == IW'(gi));
      assign gnt[gi]          = (state_reg == GRANT) && owner_onehot[gi] && !fifo_full && !rst;
      assign slice_data[gi]   = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [IW-1:0] idle_idx;
  logic          idle_any;
  logic [IW-1:0] re_idx;
  logic          re_any;

  rr_pick #(.N(N_REQ), .IW(IW)) u_idle_pick (
    .req  (req),
    .last (last_reg),
    .idx  (idle_idx),
    .any  (idle_any)
  );

  // Others first; the old owner only keeps the port when nobody else asks.
  rr_pick #(.N(N_REQ), .IW(IW)) u_re_pick (
    .req  (req & ~owner_onehot),
    .last (owner_reg),
    .idx  (re_idx),
    .any  (re_any)
  );

  logic          owner_req;
  logic          beat;
  logic          last_beat;
  logic          burst_done;
  logic          rel;
  logic [IW-1:0] next_owner;

  assign owner_req    = |(req & owner_onehot);
  assign beat         = |(req & gnt);
  assign last_beat    = |(req & req_last & gnt);
  assign burst_done   = beat && (cnt_reg == CW'(MAX_BURST - 1));
  assign rel          = (state_reg == GRANT) && (last_beat || burst_done || !owner_req);
  assign next_owner   = re_any ? re_idx : owner_reg;

  assign fifo_wq      = beat;
  assign fifo_wr_data = slice_data[owner_reg];
  assign owner        = owner_reg;
  assign busy         = (state_reg == GRANT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= IW'(N_REQ - 1);
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (idle_any) begin
            state_reg <= GRANT;
            owner_reg <= idle_idx;
            cnt_reg   <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            last_reg <= owner_reg;
            cnt_reg  <= '0;
            if (|req) begin
              owner_reg <= next_owner;
            end else begin
              state_reg <= IDLE;
            end
          end else if (beat) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: stimulus pushes expected FIFO writes, a negedge monitor
// pops and compares whenever the arbiter writes.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    logic [1:0]    own;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, req_last, gnt;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_wq, busy;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      owner;

  logic [N-1:0]    req2, gnt2;
  logic [N*DW-1:0] req_data2;
  logic            fifo_wq2, busy2;
  logic [DW-1:0]   fifo_wr_data2;
  logic [1:0]      owner2;

  logic [3:0]   sent [N];
  logic [3:0]   sent2;
  logic [N-1:0] last_en;
  logic [3:0]   last_beat [N];

  beat_t exp_q[$];
  beat_t exp_q2[$];
  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .fifo_full(fifo_full), .fifo_wq(fifo_wq), .fifo_wr_data(fifo_wr_data),
    .owner(owner), .busy(busy)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .req_last(4'b0000),
    .gnt(gnt2), .fifo_full(1'b0), .fifo_wq(fifo_wq2), .fifo_wr_data(fifo_wr_data2),
    .owner(owner2), .busy(busy2)
  );

  // Producer model: each requester sends {index, sequence number}.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_prod
      assign req_data[gi*DW +: DW] = {4'(gi), sent[gi]};
      assign req_last[gi]          = last_en[gi] && (sent[gi] == last_beat[gi]);
    end
  endgenerate
  assign req_data2 = {24'd0, 4'd0, sent2};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) sent[i] <= 4'd0;
      else if (req[i] && gnt[i]) sent[i] <= sent[i] + 4'd1;
    end
    if (rst) sent2 <= 4'd0;
    else if (req2[0] && gnt2[0]) sent2 <= sent2 + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input int o, input int s);
    beat_t b;
    b.own  = 2'(o);
    b.data = {4'(o), 4'(s)};
    exp_q.push_back(b);
  endtask

  task automatic exp_beat2(input int s);
    beat_t b;
    b.own  = 2'd0;
    b.data = {4'd0, 4'(s)};
    exp_q2.push_back(b);
  endtask

  // Monitor
  always @(negedge clk) begin
    beat_t e;
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (fifo_wq) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got owner %0d data %0h expected no write", owner, fifo_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_owner", 32'(owner), 32'(e.own));
        check("beat_data", 32'(fifo_wr_data), 32'(e.data));
      end
    end
    if (fifo_wq2) begin
      if (exp_q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat2: got data %0h expected no write", fifo_wr_data2);
      end else begin
        e = exp_q2.pop_front();
        check("beat2_owner", 32'(owner2), 32'(e.own));
        check("beat2_data", 32'(fifo_wr_data2), 32'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; req2 = '0; fifo_full = 1'b0; last_en = '0;
    for (int i = 0; i < N; i++) last_beat[i] = 4'd0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_wq", 32'(fifo_wq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);

    // Two requesters alternate full bursts with no gap.
    step();
    req = 4'b0101;
    for (int s = 0; s < 4; s++) exp_beat(0, s);
    for (int s = 0; s < 4; s++) exp_beat(2, s);
    for (int s = 4; s < 8; s++) exp_beat(0, s);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_gnt", 32'(gnt), 32'd0);
    step();
    @(negedge clk);
    check("t1_first_busy", 32'(busy), 32'd1);
    check("t1_first_owner", 32'(owner), 32'd0);
    check("t1_first_wq", 32'(fifo_wq), 32'd1);
    repeat (12) step();
    req = 4'b0000;
    check("t1_all_beats", 32'(exp_q.size()), 32'd0);
    step();
    @(negedge clk);
    check("t1_end_busy", 32'(busy), 32'd0);

    // req_last ends a burst early; pending requester takes over next cycle.
    step();
    req = 4'b0010; last_en[1] = 1'b1; last_beat[1] = 4'd1;
    exp_beat(1, 0); exp_beat(1, 1); exp_beat(3, 0); exp_beat(3, 1);
    step();
    req = 4'b1010; last_en[3] = 1'b1; last_beat[3] = 4'd1;
    @(negedge clk);
    check("t2_owner1", 32'(owner), 32'd1);
    check("t2_gnt1", 32'(gnt), 32'b0010);
    step();
    step();
    req = 4'b1000;
    @(negedge clk);
    check("t2_owner3", 32'(owner), 32'd3);
    check("t2_gnt3", 32'(gnt), 32'b1000);
    step();
    step();
    req = 4'b0000; last_en = '0;
    step();
    check("t2_all_beats", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t2_end_busy", 32'(busy), 32'd0);

    // FIFO full stalls owner 0 at cnt=2; burst finishes after 2 more beats.
    step();
    req = 4'b0011;
    for (int s = 8; s < 12; s++) exp_beat(0, s);
    step();
    step();
    step();
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall_gnt", 32'(gnt), 32'd0);
      check("t3_stall_wq", 32'(fifo_wq), 32'd0);
      check("t3_stall_busy", 32'(busy), 32'd1);
      step();
    end
    fifo_full = 1'b0;
    step();
    step();
    req = 4'b0000;
    @(negedge clk);
    check("t3_handover_owner", 32'(owner), 32'd1);
    check("t3_handover_busy", 32'(busy), 32'd1);
    step();
    check("t3_all_beats", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t3_end_busy", 32'(busy), 32'd0);

    // Owner 2 drops req while full; last=2 shows in the next pick.
    step();
    req = 4'b0100;
    step();
    fifo_full = 1'b1;
    @(negedge clk);
    check("t4_owner2", 32'(owner), 32'd2);
    check("t4_full_gnt", 32'(gnt), 32'd0);
    step();
    req = 4'b0000;
    step();
    fifo_full = 1'b0; req = 4'b0110;
    exp_beat(1, 2);
    @(negedge clk);
    check("t4_idle_busy", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    check("t4_rr_owner", 32'(owner), 32'd1);
    check("t4_rr_gnt", 32'(gnt), 32'b0010);
    check("t4_rr_wq", 32'(fifo_wq), 32'd1);

    // Reset during an active beat from owner 1.
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    check("t5_rst_wq", 32'(fifo_wq), 32'd0);
    step();
    rst = 1'b0; req = 4'b1111;
    check("t5_all_beats", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t5_post_busy", 32'(busy), 32'd0);
    check("t5_post_owner", 32'(owner), 32'd0);
    step();
    req = 4'b0000;
    @(negedge clk);
    check("t5_first_owner", 32'(owner), 32'd0);
    check("t5_first_gnt", 32'(gnt), 32'b0001);
    check("t5_first_busy", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    check("t5_end_busy", 32'(busy), 32'd0);

    // Single requester, MAX_BURST=2: self-regrant with no bubble.
    step();
    req2 = 4'b0001;
    for (int s = 0; s < 6; s++) exp_beat2(s);
    step();
    @(negedge clk);
    check("t6_busy2", 32'(busy2), 32'd1);
    check("t6_owner2", 32'(owner2), 32'd0);
    repeat (6) step();
    req2 = 4'b0000;
    check("t6_all_beats", 32'(exp_q2.size()), 32'd0);
    step();
    @(negedge clk);
    check("t6_end_busy2", 32'(busy2), 32'd0);

    step();
    check("final_q", 32'(exp_q.size()), 32'd0);
    check("final_q2", 32'(exp_q2.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
